// File: rtl/perf_tcp_csr_pkg.sv
// Shared AXI-Lite widths, register map and queue entry type for the TCP listen CSR block.
package lynxTypes;
    localparam int AXIL_DATA_BITS = 64;
    localparam int AXIL_ADDR_BITS = 64;
endpackage

package perf_tcp_csr_pkg;
    localparam int AXIL_DATA_BITS = lynxTypes::AXIL_DATA_BITS;
    localparam int AXIL_ADDR_BITS = lynxTypes::AXIL_ADDR_BITS;
    localparam int ADDR_LSB       = $clog2(AXIL_DATA_BITS / 8);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PORT     = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_RSP_POP  = 3'd3;
    localparam logic [2:0] REG_OK_CNT   = 3'd4;
    localparam logic [2:0] REG_FAIL_CNT = 3'd5;
    localparam logic [2:0] REG_REQ_CNT  = 3'd6;
    localparam logic [2:0] REG_RSVD     = 3'd7;

    typedef struct packed {
        logic [15:0] port;
        logic [7:0]  status;
    } rsp_entry_t;

    typedef enum logic {REQ_IDLE, REQ_SEND} req_state_t;
    typedef enum logic [1:0] {AXI_IDLE, AXI_ACK, AXI_RESP} axi_state_t;
endpackage

// File: rtl/tcp_listen_rsp_fifo.sv
// Synchronous FIFO with combinational head; a pop frees a slot for a same-cycle push when full.
module tcp_listen_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_CNT = DEPTH[PTR_BITS:0];

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_BITS + 1)'(1);
                2'b01:   count <= count - (PTR_BITS + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/tcp_listen_csr_mq.sv
// AXI-Lite CSR front end that issues TCP listen requests and queues their responses for the host.
module tcp_listen_csr_mq
    import perf_tcp_csr_pkg::*;
#(
    parameter int RSP_DEPTH = 8,
    parameter int CNT_BITS  = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIL_ADDR_BITS-1:0]   axi_ctrl_awaddr,
    input  logic                        axi_ctrl_awvalid,
    output logic                        axi_ctrl_awready,
    input  logic [AXIL_DATA_BITS-1:0]   axi_ctrl_wdata,
    input  logic [AXIL_DATA_BITS/8-1:0] axi_ctrl_wstrb,
    input  logic                        axi_ctrl_wvalid,
    output logic                        axi_ctrl_wready,
    output logic [1:0]                  axi_ctrl_bresp,
    output logic                        axi_ctrl_bvalid,
    input  logic                        axi_ctrl_bready,
    input  logic [AXIL_ADDR_BITS-1:0]   axi_ctrl_araddr,
    input  logic                        axi_ctrl_arvalid,
    output logic                        axi_ctrl_arready,
    output logic [AXIL_DATA_BITS-1:0]   axi_ctrl_rdata,
    output logic [1:0]                  axi_ctrl_rresp,
    output logic                        axi_ctrl_rvalid,
    input  logic                        axi_ctrl_rready,
    output logic                        listen_req_valid,
    input  logic                        listen_req_ready,
    output logic [15:0]                 listen_req_port,
    input  logic                        listen_rsp_valid,
    output logic                        listen_rsp_ready,
    input  logic [7:0]                  listen_rsp_data
);
    localparam int OCC_BITS = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    axi_state_t wr_state, wr_next, rd_state, rd_next;
    req_state_t req_state, req_next;

    logic                      wr_fire, rd_fire, req_fire, rsp_fire;
    logic [2:0]                wr_idx, rd_idx;
    logic                      go, clr_cnt, clr_err;
    logic                      go_accept, go_reject;
    logic [15:0]               port_reg;
    logic                      err_go, err_drop;
    logic [CNT_BITS-1:0]       ok_cnt, fail_cnt, req_cnt;
    logic [AXIL_DATA_BITS-1:0] rd_word;
    logic                      inf_full, inf_empty;
    logic [15:0]               inf_head;
    logic [OCC_BITS-1:0]       inf_count;
    logic                      rsp_full, rsp_empty, rsp_pop;
    rsp_entry_t                rsp_head, rsp_push_entry;
    logic [OCC_BITS-1:0]       rsp_count;
    logic                      unused_bits;

    assign wr_idx    = axi_ctrl_awaddr[ADDR_LSB +: 3];
    assign rd_idx    = axi_ctrl_araddr[ADDR_LSB +: 3];
    assign wr_fire   = (wr_state == AXI_ACK);
    assign rd_fire   = (rd_state == AXI_ACK);
    assign go_accept = go && (req_state == REQ_IDLE) && !inf_full;
    assign go_reject = go && !go_accept;
    assign req_fire  = listen_req_valid && listen_req_ready;
    assign rsp_fire  = listen_rsp_valid && listen_rsp_ready;
    assign rsp_pop   = rd_fire && (rd_idx == REG_RSP_POP) && !rsp_empty;
    assign listen_rsp_ready = aresetn && !rsp_full && !inf_empty;
    assign rsp_push_entry   = '{port: inf_head, status: listen_rsp_data};
    assign unused_bits = ^{axi_ctrl_awaddr, axi_ctrl_araddr, axi_ctrl_wdata[AXIL_DATA_BITS-1:16],
                           axi_ctrl_wstrb[AXIL_DATA_BITS/8-1:2], inf_count};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state  <= AXI_IDLE;
            rd_state  <= AXI_IDLE;
            req_state <= REQ_IDLE;
        end else begin
            wr_state  <= wr_next;
            rd_state  <= rd_next;
            req_state <= req_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            AXI_IDLE: if (axi_ctrl_awvalid && axi_ctrl_wvalid) wr_next = AXI_ACK;
            AXI_ACK:  wr_next = AXI_RESP;
            AXI_RESP: if (axi_ctrl_bready) wr_next = AXI_IDLE;
            default:  wr_next = AXI_IDLE;
        endcase
        rd_next = rd_state;
        case (rd_state)
            AXI_IDLE: if (axi_ctrl_arvalid) rd_next = AXI_ACK;
            AXI_ACK:  rd_next = AXI_RESP;
            AXI_RESP: if (axi_ctrl_rready) rd_next = AXI_IDLE;
            default:  rd_next = AXI_IDLE;
        endcase
        req_next = req_state;
        case (req_state)
            REQ_IDLE: if (go_accept) req_next = REQ_SEND;
            REQ_SEND: if (listen_req_ready) req_next = REQ_IDLE;
            default:  req_next = REQ_IDLE;
        endcase
    end

    always_comb begin
        axi_ctrl_awready = (wr_state == AXI_ACK);
        axi_ctrl_wready  = (wr_state == AXI_ACK);
        axi_ctrl_bvalid  = (wr_state == AXI_RESP);
        axi_ctrl_bresp   = 2'b00;
        axi_ctrl_arready = (rd_state == AXI_ACK);
        axi_ctrl_rvalid  = (rd_state == AXI_RESP);
        axi_ctrl_rresp   = 2'b00;
        listen_req_valid = (req_state == REQ_SEND);
    end

    // CTRL bits are W1S pulses that live for exactly one cycle after the write handshake.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            go       <= 1'b0;
            clr_cnt  <= 1'b0;
            clr_err  <= 1'b0;
            port_reg <= '0;
        end else begin
            go      <= wr_fire && (wr_idx == REG_CTRL) && axi_ctrl_wstrb[0] && axi_ctrl_wdata[0];
            clr_cnt <= wr_fire && (wr_idx == REG_CTRL) && axi_ctrl_wstrb[0] && axi_ctrl_wdata[1];
            clr_err <= wr_fire && (wr_idx == REG_CTRL) && axi_ctrl_wstrb[0] && axi_ctrl_wdata[2];
            if (wr_fire && (wr_idx == REG_PORT)) begin
                if (axi_ctrl_wstrb[0]) port_reg[7:0]  <= axi_ctrl_wdata[7:0];
                if (axi_ctrl_wstrb[1]) port_reg[15:8] <= axi_ctrl_wdata[15:8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            listen_req_port <= '0;
            err_go          <= 1'b0;
            err_drop        <= 1'b0;
        end else begin
            if (go_accept) listen_req_port <= port_reg;
            if (go_reject) err_go <= 1'b1;
            else if (clr_err) err_go <= 1'b0;
            if (listen_rsp_valid && rsp_full) err_drop <= 1'b1;
            else if (clr_err) err_drop <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || clr_cnt) begin
            ok_cnt   <= '0;
            fail_cnt <= '0;
            req_cnt  <= '0;
        end else begin
            if (req_fire) req_cnt <= req_cnt + CNT_ONE;
            if (rsp_fire) begin
                if (listen_rsp_data[0]) ok_cnt <= ok_cnt + CNT_ONE;
                else fail_cnt <= fail_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            REG_PORT:   rd_word[15:0] = port_reg;
            REG_STATUS: begin
                rd_word[0] = !rsp_empty;
                rd_word[1] = (req_state == REQ_SEND);
                rd_word[2] = err_go;
                rd_word[3] = err_drop;
                rd_word[8 +: OCC_BITS] = rsp_count;
            end
            REG_RSP_POP: if (!rsp_empty) begin
                rd_word[31:16] = rsp_head.port;
                rd_word[7:0]   = rsp_head.status;
            end
            REG_OK_CNT:   rd_word[CNT_BITS-1:0] = ok_cnt;
            REG_FAIL_CNT: rd_word[CNT_BITS-1:0] = fail_cnt;
            REG_REQ_CNT:  rd_word[CNT_BITS-1:0] = req_cnt;
            default:      rd_word = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) axi_ctrl_rdata <= '0;
        else if (rd_fire) axi_ctrl_rdata <= rd_word;
    end

    tcp_listen_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(16)) u_inflight (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (req_fire),
        .push_data (listen_req_port),
        .pop       (rsp_fire),
        .head      (inf_head),
        .full      (inf_full),
        .empty     (inf_empty),
        .count     (inf_count)
    );

    tcp_listen_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH($bits(rsp_entry_t))) u_rsp_queue (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (rsp_fire),
        .push_data (rsp_push_entry),
        .pop       (rsp_pop),
        .head      (rsp_head),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );
endmodule
